// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: MMIO register offsets and
// the address-class enum produced by the decoder.
package mips_mem_responder_pkg;

   localparam logic [15:0] OFF_CYC = 16'h0000;
   localparam logic [15:0] OFF_STC = 16'h0004;
   localparam logic [15:0] OFF_IO  = 16'h0008;
   localparam logic [15:0] OFF_ERR = 16'h000C;

   typedef enum logic [1:0] {
      DEC_RAM  = 2'd0,
      DEC_MMIO = 2'd1,
      DEC_BAD  = 2'd2
   } dec_e;

   function automatic logic mmio_known(input logic [15:0] off);
      return (off == OFF_CYC) || (off == OFF_STC) || (off == OFF_IO) || (off == OFF_ERR);
   endfunction

endpackage

// File: rtl/mips_mem_decode.sv
// Combinational byte-address classifier: RAM word, MMIO register or bad access.
module mips_mem_decode
   import mips_mem_responder_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
   input  logic [31:0]   addr,
   output dec_e          cls,
   output logic [AW-1:0] index,
   output logic [15:0]   offset
);

   logic aligned;
   logic in_ram;
   logic in_mmio;

   assign aligned = (addr[1:0] == 2'b00);
   // RAM spans 0 .. 4*2**AW-1, i.e. every bit above the word index is zero.
   assign in_ram  = (addr[31:AW+2] == '0);
   assign in_mmio = (addr[31:16] == MMIO_HI);
   assign index   = addr[AW+1:2];
   assign offset  = addr[15:0];

   always_comb begin
      cls = DEC_BAD;
      if (aligned) begin
         if (in_ram) begin
            cls = DEC_RAM;
         end else if (in_mmio) begin
            cls = DEC_MMIO;
         end
      end
   end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the five-stage MIPS core: unified RAM with fetch and
// data read ports, one write port shared by the loader and core stores, and MMIO.
module mips_mem_responder
   import mips_mem_responder_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   pc_address,
   output logic [31:0]   ins_out,
   input  logic          load,
   input  logic          store,
   input  logic [31:0]   mem_address,
   input  logic [31:0]   mem_wdata,
   output logic [31:0]   mem_rdata,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data,
   output logic [31:0]   io_out,
   output logic          err
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [31:0] ram [DEPTH];

   dec_e          f_cls;
   logic [AW-1:0] f_idx;
   logic [15:0]   unused_f_off;
   dec_e          d_cls;
   logic [AW-1:0] d_idx;
   logic [15:0]   d_off;

   logic [31:0] cyc_q, cyc_d;
   logic [31:0] stc_q, stc_d;
   logic [31:0] io_q, io_d;
   logic        err_q, err_d;

   logic d_ram;
   logic d_bad;
   logic err_set;
   logic err_clr;

   mips_mem_decode #(
      .AW      (AW),
      .MMIO_HI (MMIO_HI)
   ) u_fetch_dec (
      .addr   (pc_address),
      .cls    (f_cls),
      .index  (f_idx),
      .offset (unused_f_off)
   );

   mips_mem_decode #(
      .AW      (AW),
      .MMIO_HI (MMIO_HI)
   ) u_data_dec (
      .addr   (mem_address),
      .cls    (d_cls),
      .index  (d_idx),
      .offset (d_off)
   );

   assign d_ram = (d_cls == DEC_RAM);
   // Misaligned, unmapped and unknown MMIO offsets are faults for reads and writes alike.
   assign d_bad = (d_cls == DEC_BAD) || ((d_cls == DEC_MMIO) && !mmio_known(d_off));

   assign ins_out = (f_cls == DEC_RAM) ? ram[f_idx] : 32'h0000_0000;

   always_comb begin
      mem_rdata = 32'h0000_0000;
      if (load) begin
         if (d_ram) begin
            mem_rdata = ram[d_idx];
         end else if (d_cls == DEC_MMIO) begin
            case (d_off)
               OFF_CYC: mem_rdata = cyc_q;
               OFF_STC: mem_rdata = stc_q;
               OFF_IO:  mem_rdata = io_q;
               OFF_ERR: mem_rdata = {31'b0, err_q};
               default: mem_rdata = 32'h0000_0000;
            endcase
         end
      end
   end

   // Loader owns the write port whenever it strobes; it must work under reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else if (store && reset && d_ram) begin
         ram[d_idx] <= mem_wdata;
      end
   end

   assign err_set = (f_cls != DEC_RAM) || (load && d_bad) || (store && d_bad);
   assign err_clr = store && (d_cls == DEC_MMIO) && (d_off == OFF_ERR);

   always_comb begin
      cyc_d = cyc_q + 32'd1;
      stc_d = stc_q;
      io_d  = io_q;
      err_d = err_q | err_set;
      if (store && d_ram) begin
         stc_d = stc_q + 32'd1;
      end
      if (store && (d_cls == DEC_MMIO) && (d_off == OFF_IO)) begin
         io_d = mem_wdata;
      end
      if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= 32'h0000_0000;
         stc_q <= 32'h0000_0000;
         io_q  <= 32'h0000_0000;
         err_q <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         stc_q <= stc_d;
         io_q  <= io_d;
         err_q <= err_d;
      end
   end

   assign io_out = io_q;
   assign err    = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: vector table plus hand-written
// sequences for loader-in-reset, cycle count, async reset and loader collision.
module tb_mips_mem_responder;

   localparam int unsigned AW = 10;
   localparam logic [31:0] INS8 = 32'h01095020;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pc_address;
   logic [31:0]   ins_out;
   logic          load;
   logic          store;
   logic [31:0]   mem_address;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic [31:0]   io_out;
   logic          err;

   int checks = 0;
   int errors = 0;

   mips_mem_responder #(
      .AW      (AW),
      .MMIO_HI (16'hFFFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_address  (pc_address),
      .ins_out     (ins_out),
      .load        (load),
      .store       (store),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .io_out      (io_out),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] exp_rdata;
      logic [31:0] exp_ins;
      logic [31:0] exp_io;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] pc, input logic [31:0] exp_rdata,
                               input logic [31:0] exp_ins, input logic [31:0] exp_io,
                               input logic exp_err);
      vec_t v;
      v.name = name; v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.pc = pc;
      v.exp_rdata = exp_rdata; v.exp_ins = exp_ins; v.exp_io = exp_io; v.exp_err = exp_err;
      return v;
   endfunction

   // Combinational data read between edges; leaves load deasserted.
   task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
      load = 1'b1;
      mem_address = a;
      #1;
      chk(name, mem_rdata, exp);
      load = 1'b0;
   endtask

   logic [AW-1:0] img_addr [5];
   logic [31:0]   img_data [5];

   initial begin
      img_addr[0] = 10'd0;  img_data[0] = 32'h20080005;
      img_addr[1] = 10'd1;  img_data[1] = 32'h20090007;
      img_addr[2] = 10'd2;  img_data[2] = INS8;
      img_addr[3] = 10'd3;  img_data[3] = 32'hAC0A0040;
      img_addr[4] = 10'd16; img_data[4] = 32'h11111111;

      //      name                ld    st    addr          wdata         pc            rdata         ins    io            err
      vecs.push_back(mk("store_load_same", 1'b1, 1'b1, 32'h00000040, 32'hDEADBEEF, 32'h8, 32'h11111111, INS8, 32'h0, 1'b0));
      vecs.push_back(mk("load_after_store", 1'b1, 1'b0, 32'h00000040, 32'h0, 32'h8, 32'hDEADBEEF, INS8, 32'h0, 1'b0));
      vecs.push_back(mk("stcnt_one", 1'b1, 1'b0, 32'hFFFF0004, 32'h0, 32'h8, 32'h1, INS8, 32'h0, 1'b0));
      vecs.push_back(mk("io_store", 1'b0, 1'b1, 32'hFFFF0008, 32'hA5, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("io_read", 1'b1, 1'b0, 32'hFFFF0008, 32'h0, 32'h8, 32'hA5, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("cyc_store_ign", 1'b0, 1'b1, 32'hFFFF0000, 32'h123, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("stc_store_ign", 1'b0, 1'b1, 32'hFFFF0004, 32'h456, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("err_read_0", 1'b1, 1'b0, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("load_misalign", 1'b1, 1'b0, 32'h00000041, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_read_1", 1'b1, 1'b0, 32'hFFFF000C, 32'h0, 32'h8, 32'h1, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_clear", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("mmio_bad_off", 1'b1, 1'b0, 32'hFFFF0010, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_clear_2", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("store_misalign", 1'b0, 1'b1, 32'h00000042, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_clear_3", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("ram_intact", 1'b1, 1'b0, 32'h00000040, 32'h0, 32'h8, 32'hDEADBEEF, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("store_unmapped", 1'b0, 1'b1, 32'h00002000, 32'h77, 32'h8, 32'h0, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_clear_4", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("load_past_ram", 1'b1, 1'b0, 32'h00001000, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b1));
      vecs.push_back(mk("err_clear_5", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h8, 32'h0, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("fetch_past_ram", 1'b0, 1'b0, 32'h00000000, 32'h0, 32'h1000, 32'h0, 32'h0, 32'hA5, 1'b1));
      vecs.push_back(mk("fetch_err_clear", 1'b0, 1'b1, 32'hFFFF000C, 32'h0, 32'h1000, 32'h0, 32'h0, 32'hA5, 1'b0));
      vecs.push_back(mk("stcnt_still_one", 1'b1, 1'b0, 32'hFFFF0004, 32'h0, 32'h8, 32'h1, INS8, 32'hA5, 1'b0));
      vecs.push_back(mk("fetch_misalign", 1'b0, 1'b0, 32'h00000000, 32'h0, 32'h9, 32'h0, 32'h0, 32'hA5, 1'b1));

      reset = 1'b0;
      pc_address = 32'h8;
      load = 1'b0; store = 1'b0;
      mem_address = 32'h0; mem_wdata = 32'h0;
      ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;

      // Program image is loaded while the core is held in reset.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = img_addr[i]; ld_data = img_data[i];
      end
      @(negedge clk);
      ld_en = 1'b0;
      peek("reset_cyc", 32'hFFFF0000, 32'h0);
      chk("reset_io", io_out, 32'h0);
      chk("reset_err", {31'b0, err}, 32'h0);

      reset = 1'b1;
      #1;
      chk("fetch_pc8", ins_out, INS8);
      pc_address = 32'h0;
      #1;
      chk("fetch_pc0", ins_out, 32'h20080005);
      pc_address = 32'h8;

      repeat (10) @(posedge clk);
      #1;
      peek("cyc_after_10", 32'hFFFF0000, 32'd10);
      chk("err_after_boot", {31'b0, err}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         load = vecs[i].ld; store = vecs[i].st;
         mem_address = vecs[i].addr; mem_wdata = vecs[i].wdata;
         pc_address = vecs[i].pc;
         #1;
         chk({vecs[i].name, "_rdata"}, mem_rdata, vecs[i].exp_rdata);
         chk({vecs[i].name, "_ins"}, ins_out, vecs[i].exp_ins);
         @(posedge clk);
         #1;
         load = 1'b0; store = 1'b0; pc_address = 32'h8;
         chk({vecs[i].name, "_io"}, io_out, vecs[i].exp_io);
         chk({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
      end

      // Asynchronous reset between edges with err=1 and io_out=0xA5 beforehand.
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_io", io_out, 32'h0);
      chk("async_err", {31'b0, err}, 32'h0);
      peek("async_cyc", 32'hFFFF0000, 32'h0);
      peek("async_stc", 32'hFFFF0004, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      peek("ram_survives_reset", 32'h00000040, 32'hDEADBEEF);

      // Loader and store hit word 0x10 in the same cycle: loader data lands.
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 10'h10; ld_data = 32'hCAFEF00D;
      store = 1'b1; mem_address = 32'h00000040; mem_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      ld_en = 1'b0; store = 1'b0;
      peek("collision_data", 32'h00000040, 32'hCAFEF00D);
      peek("collision_stc", 32'hFFFF0004, 32'h1);
      chk("collision_err", {31'b0, err}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
